// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage controller for a multi-cycle divider.
// Drives the start/annul handshake, stalls the pipeline while a divide is
// outstanding, and owns the HI/LO pair (divide results plus MTHI/MTLO).
// Optional build macro: DIV_ZERO_HOLD_EN -- a divide by zero leaves HI/LO
// untouched instead of committing the divider's result.
module div_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] div_op1_i,
  input  logic [31:0] div_op2_i,
  input  logic        flush_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hilo_wdata_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t            state;
  state_t            state_next;
  logic              op_signed;
  logic [31:0]       opdata1;
  logic [31:0]       opdata2;
  logic [63:0]       hold;
  logic [CNT_W-1:0]  drain_cnt;
  logic [31:0]       hi;
  logic [31:0]       lo;
  logic              latch_ops;
  logic              latch_res;
  logic              load_cnt;
  logic              commit;

`ifdef DIV_ZERO_HOLD_EN
  logic              zero_div;
`endif

  assign div_signed_o  = op_signed;
  assign div_opdata1_o = opdata1;
  assign div_opdata2_o = opdata2;
  assign hi_o          = hi;
  assign lo_o          = lo;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, handshake outputs, stall and internal load strobes.
  always_comb begin
    state_next  = state;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    stall_o     = 1'b0;
    latch_ops   = 1'b0;
    latch_res   = 1'b0;
    load_cnt    = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        stall_o = div_req_i & ~flush_i;
        if (div_req_i && !flush_i) begin
          latch_ops  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        div_start_o = 1'b1;
        stall_o     = 1'b1;
        // A flush cancels the divide even if the result arrives this cycle.
        if (flush_i) begin
          load_cnt   = 1'b1;
          state_next = DRAIN;
        end else if (div_ready_i) begin
          latch_res  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // The request still visible here is the retiring divide; ignore it.
`ifdef DIV_ZERO_HOLD_EN
        commit = ~flush_i & ~zero_div;
`else
        commit = ~flush_i;
`endif
        state_next = IDLE;
      end
      DRAIN: begin
        div_annul_o = 1'b1;
        stall_o     = div_req_i;
        if (drain_cnt <= CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture at the request cycle; held steady for the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_signed <= 1'b0;
      opdata1   <= '0;
      opdata2   <= '0;
    end else if (latch_ops) begin
      op_signed <= div_signed_i;
      opdata1   <= div_op1_i;
      opdata2   <= div_op2_i;
    end
  end

`ifdef DIV_ZERO_HOLD_EN
  // Remember a zero divisor so DONE can skip the HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            zero_div <= 1'b0;
    else if (latch_ops) zero_div <= (div_op2_i == 32'd0);
  end
`endif

  // Divider result holding register, filled when ready is seen in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hold <= '0;
    else if (latch_res) hold <= div_result_i;
  end

  // Post-abort drain counter: annul stays up while it runs down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drain_cnt <= '0;
    else if (load_cnt)
      drain_cnt <= CNT_W'(DRAIN_CYCLES);
    else if (state == DRAIN && drain_cnt != '0)
      drain_cnt <= drain_cnt - CNT_W'(1);
  end

  // HI register: divide commit takes priority over a same-cycle MTHI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hi <= '0;
    else if (commit)  hi <= hold[63:32];
    else if (hi_we_i) hi <= hilo_wdata_i;
  end

  // LO register: divide commit takes priority over a same-cycle MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lo <= '0;
    else if (commit)  lo <= hold[31:0];
    else if (lo_we_i) lo <= hilo_wdata_i;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl. The bench plays the divider: it returns
// hand-computed {remainder, quotient} results after a chosen latency.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_op1 = '0;
  logic [31:0] div_op2 = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] hilo_wdata = '0;
  logic        div_start;
  logic        div_annul;
  logic        div_signed_out;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic [63:0] div_result = '0;
  logic        div_ready = 1'b0;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req),
    .div_signed_i (div_signed),
    .div_op1_i    (div_op1),
    .div_op2_i    (div_op2),
    .flush_i      (flush),
    .hi_we_i      (hi_we),
    .lo_we_i      (lo_we),
    .hilo_wdata_i (hilo_wdata),
    .div_start_o  (div_start),
    .div_annul_o  (div_annul),
    .div_signed_o (div_signed_out),
    .div_opdata1_o(div_opdata1),
    .div_opdata2_o(div_opdata2),
    .div_result_i (div_result),
    .div_ready_i  (div_ready),
    .stall_o      (stall),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Starts in BUSY cycle 1 (just after the edge). Holds start for lat cycles,
  // returns res, then runs the DONE cycle with optional flush / MTLO.
  task automatic finish_div(input string tag, input logic [63:0] res, input int lat,
                            input logic flush_done, input logic mtlo_done,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic held;
    held = 1'b1;
    repeat (lat) begin
      @(negedge clk);
      if (!(div_start && stall && !div_annul)) held = 1'b0;
    end
    check_eq({tag, " start/stall held"}, 64'(held), 64'd1);
    @(posedge clk); #1;
    div_ready = 1'b1;
    div_result = res;
    @(posedge clk); #1;
    div_ready = 1'b0;
    div_result = '0;
    flush = flush_done;
    lo_we = mtlo_done;
    hilo_wdata = 32'h1234;
    @(negedge clk);
    check_eq({tag, " DONE start/stall"}, {62'd0, div_start, stall}, 64'd0);
    @(posedge clk); #1;
    div_req = 1'b0;
    flush = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    check_eq({tag, " idle start/annul"}, {62'd0, div_start, div_annul}, 64'd0);
    check_eq({tag, " HI"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, " LO"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input int lat,
                         input logic flush_done, input logic mtlo_done,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(posedge clk); #1;
    div_req = 1'b1;
    div_signed = sgn;
    div_op1 = a;
    div_op2 = b;
    @(negedge clk);
    check_eq({tag, " req cycle stall/start"}, {62'd0, stall, div_start}, 64'd2);
    @(posedge clk); #1;
    check_eq({tag, " latched ops"}, {div_opdata1, div_opdata2}, {a, b});
    check_eq({tag, " latched signed"}, 64'(div_signed_out), 64'(sgn));
    finish_div(tag, res, lat, flush_done, mtlo_done, exp_hi, exp_lo);
  endtask

  task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
    @(posedge clk); #1;
    hi_we = whi;
    lo_we = wlo;
    hilo_wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset outputs", {59'd0, div_start, div_annul, div_signed_out, stall, 1'b0}, 64'd0);
    check_eq("reset opdata", {div_opdata1, div_opdata2}, 64'd0);
    check_eq("reset hi/lo", {hi, lo}, 64'd0);
    rst = 1'b0;

    // DIVU 100/7: q=14, r=2
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, 1'b0, 32'd2, 32'd14);
    // DIV -7/2: q=-3, r=-1
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 20,
            1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Flush 10 cycles into BUSY, then back-to-back DIVU 9/3 from DRAIN
    @(posedge clk); #1;
    div_req = 1'b1; div_signed = 1'b0; div_op1 = 32'd1000; div_op2 = 32'd10;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("flush cycle start/stall", {62'd0, div_start, stall}, 64'd3);
    @(posedge clk); #1;
    flush = 1'b0; div_req = 1'b0;
    @(negedge clk);
    check_eq("drain1 annul/start/stall", {61'd0, div_annul, div_start, stall}, 64'd4);
    @(posedge clk); #1;
    div_req = 1'b1; div_op1 = 32'd9; div_op2 = 32'd3;
    @(negedge clk);
    check_eq("drain2 annul/start/stall", {61'd0, div_annul, div_start, stall}, 64'd5);
    @(posedge clk); #1;
    check_eq("post-drain idle annul/start/stall", {61'd0, div_annul, div_start, stall}, 64'd1);
    check_eq("flush hi/lo unchanged", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(posedge clk); #1;
    check_eq("b2b busy start", 64'(div_start), 64'd1);
    check_eq("b2b latched ops", {div_opdata1, div_opdata2}, {32'd9, 32'd3});
    finish_div("divu 9/3", {32'd0, 32'd3}, 6, 1'b0, 1'b0, 32'd0, 32'd3);

    // Flush during DONE: no HI/LO write
    run_div("flush in done", 1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 8, 1'b1, 1'b0, 32'd0, 32'd3);

    // Divide by zero with HI/LO preloaded to 0x55
    write_hilo(1'b1, 1'b1, 32'h55);
    @(negedge clk);
    check_eq("mthi/mtlo preload", {hi, lo}, {32'h55, 32'h55});
`ifdef DIV_ZERO_HOLD_EN
    run_div("divu x/0", 1'b0, 32'h1234, 32'd0, 64'd0, 5, 1'b0, 1'b0, 32'h55, 32'h55);
`else
    run_div("divu x/0", 1'b0, 32'h1234, 32'd0, 64'd0, 5, 1'b0, 1'b0, 32'd0, 32'd0);
`endif

    // MTLO in DONE loses to the commit; a following MTHI lands
    run_div("mtlo in done", 1'b0, 32'd50, 32'd4, {32'd2, 32'd12}, 7, 1'b0, 1'b1, 32'd2, 32'd12);
    write_hilo(1'b1, 1'b0, 32'hABCD);
    @(negedge clk);
    check_eq("mthi after done", {hi, lo}, {32'hABCD, 32'd12});

    // Asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    div_req = 1'b1; div_op1 = 32'd7; div_op2 = 32'd1;
    @(posedge clk); #1;
    check_eq("pre-reset busy start", 64'(div_start), 64'd1);
    div_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async reset start/stall", {62'd0, div_start, stall}, 64'd0);
    check_eq("async reset regs", {div_opdata1, hi}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("after reset lo", 64'(lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
